// File: rtl/hazard_pkg.sv
// Shared types and constants for the registered hazard scoreboard.
// Entry field widths are fixed here; the top level checks that its parameters agree.
package hazard_pkg;

  localparam int unsigned PKG_NRD = 2;
  localparam int unsigned PKG_AW  = 5;
  localparam int unsigned PKG_TW  = 3;

  localparam int unsigned         FWD_RF    = 0;
  localparam logic [PKG_TW-1:0]   TUSE_NONE = '1;

  typedef struct packed {
    logic                            valid;
    logic [PKG_AW-1:0]               dst;
    logic [PKG_TW-1:0]               tnew;
    logic [PKG_NRD-1:0][PKG_AW-1:0]  src;
  } entry_t;

endpackage

// File: rtl/hazard_port_check.sv
// Checks one source operand against the producer entries from stage FIRST onward.
// Returns a stall bit (youngest match not ready by Tuse) and a forwarding select.
module hazard_port_check
  import hazard_pkg::*;
#(
  parameter int unsigned NSTAGE = 3,
  parameter int unsigned FIRST  = 0,
  parameter int unsigned SW     = 2
) (
  input  logic [PKG_AW-1:0]       src_i,
  input  logic [PKG_TW-1:0]       tuse_i,
  input  entry_t [NSTAGE-1:0]     entries_i,
  output logic                    stall_o,
  output logic [SW-1:0]           sel_o
);

  logic              found;
  logic [PKG_TW-1:0] hit_tnew;
  logic [SW-1:0]     hit_sel;
  logic              unused_entry_bits;

  // Walk oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    found    = 1'b0;
    hit_tnew = '0;
    hit_sel  = SW'(FWD_RF);
    for (int s = int'(NSTAGE) - 1; s >= int'(FIRST); s--) begin
      if (entries_i[s].valid && (entries_i[s].dst != '0) && (entries_i[s].dst == src_i)) begin
        found    = 1'b1;
        hit_tnew = entries_i[s].tnew;
        hit_sel  = SW'(int'(NSTAGE) - s);
      end
    end
  end

  always_comb begin
    stall_o = found && (tuse_i != TUSE_NONE) && (hit_tnew > tuse_i);
    sel_o   = (found && (hit_tnew == '0)) ? hit_sel : SW'(FWD_RF);
  end

  assign unused_entry_bits = ^entries_i;

endmodule

// File: rtl/hazard_scoreboard.sv
// Registered stall/forward controller: shifts decoded D-stage producer info through
// the downstream stages and derives the D stall, forwarding selects and a stall counter.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned NSTAGE = 3,
  parameter int unsigned NRD    = PKG_NRD,
  parameter int unsigned AW     = PKG_AW,
  parameter int unsigned TW     = PKG_TW,
  parameter int unsigned SW     = $clog2(NSTAGE + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      d_valid,
  input  logic [NRD*AW-1:0]         d_src,
  input  logic [NRD*TW-1:0]         d_tuse,
  input  logic                      d_wr_en,
  input  logic [AW-1:0]             d_wr_addr,
  input  logic [TW-1:0]             d_tnew,
  input  logic                      d_md_use,
  input  logic                      md_busy,
  output logic                      stall,
  output logic [NSTAGE*NRD*SW-1:0]  fwd_sel,
  output logic [31:0]               stall_cycles
);

  if (NRD != PKG_NRD || AW != PKG_AW || TW != PKG_TW) begin : g_param_check
    $error("hazard_scoreboard: NRD/AW/TW must match the hazard_pkg entry widths");
  end

  entry_t [NSTAGE-1:0] entries_q, entries_d;
  logic [31:0]         stall_cycles_q, stall_cycles_d;
  logic [NRD-1:0]      port_stall;

  logic [NRD-1:0][SW-1:0]     stall_sel_unused;
  logic [NSTAGE*NRD-1:0]      fwd_stall_unused;

  for (genvar p = 0; p < NRD; p++) begin : g_stall
    hazard_port_check #(
      .NSTAGE (NSTAGE),
      .FIRST  (0),
      .SW     (SW)
    ) u_stall_check (
      .src_i     (d_src[p*AW +: AW]),
      .tuse_i    (d_tuse[p*TW +: TW]),
      .entries_i (entries_q),
      .stall_o   (port_stall[p]),
      .sel_o     (stall_sel_unused[p])
    );
  end

  // Consumer c > 0 is the instruction now sitting in entry c-1.
  for (genvar c = 0; c < NSTAGE; c++) begin : g_cons
    for (genvar p = 0; p < NRD; p++) begin : g_port
      logic [AW-1:0] csrc;
      if (c == 0) begin : g_d
        assign csrc = d_src[p*AW +: AW];
      end else begin : g_pipe
        assign csrc = entries_q[c-1].src[p];
      end

      hazard_port_check #(
        .NSTAGE (NSTAGE),
        .FIRST  (c),
        .SW     (SW)
      ) u_fwd_check (
        .src_i     (csrc),
        .tuse_i    (TUSE_NONE),
        .entries_i (entries_q),
        .stall_o   (fwd_stall_unused[c*NRD+p]),
        .sel_o     (fwd_sel[(c*NRD+p)*SW +: SW])
      );
    end
  end

  // Masked by reset so a pending md stall cannot leak out while entries are cleared.
  assign stall = !reset && d_valid && ((|port_stall) || (d_md_use && md_busy));

  always_comb begin
    entries_d = '0;
    if (d_valid && !stall) begin
      entries_d[0].valid = 1'b1;
      entries_d[0].dst   = d_wr_en ? d_wr_addr : '0;
      entries_d[0].tnew  = d_tnew;
      entries_d[0].src   = d_src;
    end
    for (int s = 0; s < int'(NSTAGE) - 1; s++) begin
      entries_d[s+1] = entries_q[s];
      if (entries_q[s].tnew != '0) begin
        entries_d[s+1].tnew = entries_q[s].tnew - 1'b1;
      end
    end
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      entries_q      <= '0;
      stall_cycles_q <= '0;
    end else begin
      entries_q      <= entries_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: expectations are queued per cycle as
// stimulus is driven and compared on the falling edge of that cycle.
module tb_hazard_scoreboard;

  localparam int NSTAGE = 3;
  localparam int NRD    = 2;
  localparam int SW     = 2;
  localparam logic [2:0] NONE = 3'b111;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        d_valid = 1'b0;
  logic [9:0]  d_src = '0;
  logic [5:0]  d_tuse = '1;
  logic        d_wr_en = 1'b0;
  logic [4:0]  d_wr_addr = '0;
  logic [2:0]  d_tnew = '0;
  logic        d_md_use = 1'b0;
  logic        md_busy = 1'b0;
  logic        stall;
  logic [NSTAGE*NRD*SW-1:0] fwd_sel;
  logic [31:0] stall_cycles;

  hazard_scoreboard dut (
    .clk          (clk),
    .reset        (reset),
    .d_valid      (d_valid),
    .d_src        (d_src),
    .d_tuse       (d_tuse),
    .d_wr_en      (d_wr_en),
    .d_wr_addr    (d_wr_addr),
    .d_tnew       (d_tnew),
    .d_md_use     (d_md_use),
    .md_busy      (md_busy),
    .stall        (stall),
    .fwd_sel      (fwd_sel),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    string       tag;
    int          kind;  // 0 stall, 1 whole fwd_sel, 2 stall_cycles, 3 fwd_sel slice
    int          idx;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   cycle = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   exp_cnt = 0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", tag, cycle, got, exp);
    end
  endtask

  function automatic logic [31:0] observe(input int kind, input int idx);
    case (kind)
      0:       return {31'b0, stall};
      1:       return 32'(fwd_sel);
      2:       return stall_cycles;
      default: return 32'(fwd_sel[idx*SW +: SW]);
    endcase
  endfunction

  always @(negedge clk) begin
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (sb_q[i].cyc == cycle) begin
        check(sb_q[i].tag, observe(sb_q[i].kind, sb_q[i].idx), sb_q[i].val);
        sb_q.delete(i);
      end
    end
  end

  task automatic push(input string tag, input int off, input int kind, input int idx,
                      input logic [31:0] val);
    exp_t e;
    e.cyc = cycle + off; e.tag = tag; e.kind = kind; e.idx = idx; e.val = val;
    sb_q.push_back(e);
  endtask

  // Stall expectation for this cycle plus the counter value accumulated so far.
  task automatic exp_cyc(input string tag, input logic s);
    push({tag, "_stall"}, 0, 0, 0, {31'b0, s});
    push({tag, "_cnt"}, 0, 2, 0, 32'(exp_cnt));
    if (s) exp_cnt++;
  endtask

  task automatic exp_fwd(input string tag, input int off, input int c, input int p,
                         input logic [31:0] v);
    push(tag, off, 3, c * NRD + p, v);
  endtask

  task automatic drive(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                       input logic [2:0] u0, input logic [2:0] u1, input logic we,
                       input logic [4:0] wa, input logic [2:0] tn, input logic md,
                       input logic busy);
    @(posedge clk);
    #1;
    d_valid = v; d_src = {s1, s0}; d_tuse = {u1, u0};
    d_wr_en = we; d_wr_addr = wa; d_tnew = tn; d_md_use = md; md_busy = busy;
  endtask

  task automatic bubbles(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 5'd0, 5'd0, NONE, NONE, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0);
      exp_cyc("bubble", 1'b0);
    end
  endtask

  initial begin
    // Reset held with a valid, random D instruction
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'($urandom), 5'($urandom), 3'($urandom), 3'($urandom), 1'b1,
            5'($urandom), 3'($urandom), 1'b1, 1'b1);
      exp_cyc("rst", 1'b0);
      push("rst_fwd", 0, 1, 0, 32'd0);
    end
    drive(1'b1, 5'($urandom), 5'($urandom), 3'($urandom), 3'($urandom), 1'b0,
          5'($urandom), 3'($urandom), 1'b1, 1'b0);
    reset = 1'b0;
    exp_cyc("post_rst", 1'b0);
    push("post_rst_fwd", 0, 1, 0, 32'd0);
    bubbles(3);

    // lw $5 then addu $6,$5,$0
    drive(1'b1, 5'd0, 5'd0, NONE, NONE, 1'b1, 5'd5, 3'd2, 1'b0, 1'b0);
    exp_cyc("lw", 1'b0);
    drive(1'b1, 5'd5, 5'd0, 3'd1, 3'd1, 1'b1, 5'd6, 3'd1, 1'b0, 1'b0);
    exp_cyc("lw_use1", 1'b1);
    drive(1'b1, 5'd5, 5'd0, 3'd1, 3'd1, 1'b1, 5'd6, 3'd1, 1'b0, 1'b0);
    exp_cyc("lw_use2", 1'b0);
    exp_fwd("lw_dsel", 0, 0, 0, 32'd0);
    exp_fwd("lw_esel", 1, 1, 0, 32'd1);
    exp_fwd("lw_esel_r0", 1, 1, 1, 32'd0);
    bubbles(3);

    // addu $3 then beq $3
    drive(1'b1, 5'd0, 5'd0, NONE, NONE, 1'b1, 5'd3, 3'd1, 1'b0, 1'b0);
    exp_cyc("alu", 1'b0);
    drive(1'b1, 5'd3, 5'd0, 3'd0, 3'd0, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0);
    exp_cyc("beq1", 1'b1);
    drive(1'b1, 5'd3, 5'd0, 3'd0, 3'd0, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0);
    exp_cyc("beq2", 1'b0);
    exp_fwd("beq_dsel", 0, 0, 0, 32'd2);
    bubbles(3);

    // jal then jr $31
    drive(1'b1, 5'd0, 5'd0, NONE, NONE, 1'b1, 5'd31, 3'd0, 1'b0, 1'b0);
    exp_cyc("jal", 1'b0);
    drive(1'b1, 5'd31, 5'd0, 3'd0, NONE, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0);
    exp_cyc("jr", 1'b0);
    exp_fwd("jr_dsel", 0, 0, 0, 32'd3);
    exp_fwd("jr_esel", 1, 1, 0, 32'd2);
    bubbles(3);

    // Two writers of $4: youngest wins
    drive(1'b1, 5'd0, 5'd0, NONE, NONE, 1'b1, 5'd4, 3'd0, 1'b0, 1'b0);
    exp_cyc("w4a", 1'b0);
    drive(1'b1, 5'd0, 5'd0, NONE, NONE, 1'b1, 5'd4, 3'd0, 1'b0, 1'b0);
    exp_cyc("w4b", 1'b0);
    drive(1'b1, 5'd4, 5'd0, 3'd0, NONE, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0);
    exp_cyc("use4", 1'b0);
    exp_fwd("two_w_dsel", 0, 0, 0, 32'd3);
    exp_fwd("two_w_esel", 1, 1, 0, 32'd2);
    exp_fwd("two_w_msel", 2, 2, 0, 32'd1);
    bubbles(3);

    // Write to $0, and a wr_en=0 instruction naming $7
    drive(1'b1, 5'd0, 5'd0, NONE, NONE, 1'b1, 5'd0, 3'd2, 1'b0, 1'b0);
    exp_cyc("w0", 1'b0);
    drive(1'b1, 5'd0, 5'd0, 3'd0, 3'd0, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0);
    exp_cyc("use0", 1'b0);
    exp_fwd("r0_dsel", 0, 0, 0, 32'd0);
    drive(1'b1, 5'd0, 5'd0, NONE, NONE, 1'b0, 5'd7, 3'd2, 1'b0, 1'b0);
    exp_cyc("nowr7", 1'b0);
    drive(1'b1, 5'd7, 5'd0, 3'd0, NONE, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0);
    exp_cyc("use7", 1'b0);
    exp_fwd("nowr_dsel", 0, 0, 0, 32'd0);
    bubbles(3);

    // Younger writer of $8 not ready hides a ready older one
    drive(1'b1, 5'd0, 5'd0, NONE, NONE, 1'b1, 5'd8, 3'd0, 1'b0, 1'b0);
    exp_cyc("w8a", 1'b0);
    drive(1'b1, 5'd0, 5'd0, NONE, NONE, 1'b1, 5'd8, 3'd2, 1'b0, 1'b0);
    exp_cyc("w8b", 1'b0);
    drive(1'b1, 5'd8, 5'd8, 3'd2, NONE, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0);
    exp_cyc("use8", 1'b0);
    exp_fwd("young_dsel", 0, 0, 0, 32'd0);
    exp_fwd("young_esel", 1, 1, 0, 32'd0);
    bubbles(3);

    // mfhi under md_busy for 5 cycles
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 5'd0, 5'd0, NONE, NONE, 1'b1, 5'd9, 3'd1, 1'b1, 1'b1);
      exp_cyc("md_busy", 1'b1);
    end
    drive(1'b1, 5'd0, 5'd0, NONE, NONE, 1'b1, 5'd9, 3'd1, 1'b1, 1'b0);
    exp_cyc("md_done", 1'b0);
    drive(1'b1, 5'd0, 5'd0, NONE, NONE, 1'b0, 5'd0, 3'd0, 1'b0, 1'b1);
    exp_cyc("no_md_use", 1'b0);
    bubbles(3);

    // Data and md stall together count once per cycle
    drive(1'b1, 5'd0, 5'd0, NONE, NONE, 1'b1, 5'd10, 3'd2, 1'b0, 1'b0);
    exp_cyc("w10", 1'b0);
    drive(1'b1, 5'd10, 5'd0, 3'd0, NONE, 1'b0, 5'd0, 3'd0, 1'b1, 1'b1);
    exp_cyc("both1", 1'b1);
    drive(1'b1, 5'd10, 5'd0, 3'd0, NONE, 1'b0, 5'd0, 3'd0, 1'b1, 1'b0);
    exp_cyc("both2", 1'b1);
    drive(1'b1, 5'd10, 5'd0, 3'd0, NONE, 1'b0, 5'd0, 3'd0, 1'b1, 1'b0);
    exp_cyc("both3", 1'b0);
    exp_fwd("both_dsel", 0, 0, 0, 32'd1);
    bubbles(3);

    // Reset asserted mid-stall drops stall at once and loses the producer
    drive(1'b1, 5'd0, 5'd0, NONE, NONE, 1'b1, 5'd11, 3'd2, 1'b0, 1'b0);
    exp_cyc("w11", 1'b0);
    drive(1'b1, 5'd11, 5'd0, 3'd0, NONE, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0);
    exp_cyc("stall11", 1'b1);
    drive(1'b1, 5'd11, 5'd0, 3'd0, NONE, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0);
    reset = 1'b1;
    exp_cnt = 0;
    exp_cyc("mid_rst", 1'b0);
    push("mid_rst_fwd", 0, 1, 0, 32'd0);
    drive(1'b1, 5'd11, 5'd0, 3'd0, NONE, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0);
    reset = 1'b0;
    exp_cyc("after_rst", 1'b0);
    exp_fwd("after_rst_dsel", 0, 0, 0, 32'd0);
    bubbles(2);

    @(posedge clk);
    @(posedge clk);
    check("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised stall/forward controller for the in-order MIPS pipeline. It replaces the purely combinational hazard unit with a registered scoreboard: decoded destination, Tnew and source fields are tracked per downstream stage. The stage count, read-port count and Tnew width are all parameters. It produces the D-stage stall, operand-forwarding selects for every consuming stage, a multiply/divide-busy stall and a stall-cycle performance counter. It sits beside the D stage and is fed by the D-stage decoder.

## Interface
- `NSTAGE`, 3: producer stages after D (index 0=E, 1=M, 2=W).
- `NRD`, 2: source read ports per instruction (rs, rt).
- `AW`, 5: register address width; register 0 is hard-wired zero.
- `TW`, 3: Tuse/Tnew width.
- `SW`, $clog2(NSTAGE+1): forward-select width.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: reset is asynchronous and active-high.
- `d_valid` in 1: the D stage holds a real instruction.
- `d_src` in NRD*AW: source register addresses.
- `d_tuse` in NRD*TW: cycles from D until the operand is consumed. TUSE_NONE means the port is unused.
- `d_wr_en` in 1, `d_wr_addr` in AW: destination register.
- `d_tnew` in TW: cycles after E entry until the result is forwardable.
- `d_md_use` in 1: the instruction reads, writes or starts HI/LO.
- `md_busy` in 1: the mult/div unit is busy, including its start cycle.
- `stall` out 1: freeze PC and D, and insert a bubble into E.
- `fwd_sel` out NSTAGE*NRD*SW: select per consumer stage c (0=D, 1=E, 2=M) and port. 0 selects the register file; k selects producer stage NSTAGE-k (E=3, M=2, W=1).
- `stall_cycles` out 32: saturating count of stalled cycles.

## Operation
- Entry per stage s holds: valid, dst, tnew, src[NRD]. dst is forced to 0 when wr_en=0 or the address is 0.
- Advance on every clock edge:
  - Stage s+1 takes stage s, with tnew decremented and saturating at 0.
  - Stage 0 takes the D fields (decremented view: d_tnew as given) when `d_valid & !stall`. Otherwise stage 0 takes a bubble (valid=0, dst=0).
  - The W entry is discarded.
- Match: entry s is valid, dst != 0, and dst equals the source address.
- Stall: `d_valid` and, for some port with tuse != TUSE_NONE, the youngest matching stage has tnew > tuse. Stall is also asserted by `d_valid & d_md_use & md_busy`.
- Forwarding for consumer c, port p:
  - The search covers stages s >= c; stage c-1 holds the consumer itself.
  - Take the youngest (smallest s) matching entry. If its tnew == 0, the select is NSTAGE-s; otherwise the select is 0.
  - Older matches are ignored.
  - Consumer c>0 uses the src stored in entry c-1.
  - Address 0 always gives select 0.
- `stall_cycles` increments on every cycle with stall=1 and holds at 0xFFFFFFFF.

## Timing
- `stall` and `fwd_sel` are combinational from the current entries and the D inputs in the same cycle. Entries update on the rising clk edge.
- D fields become stage-0 state one edge after they are accepted. Each further stage adds one edge.
- Reset clears all entries asynchronously, independent of `stall`; stall-gated clearing would let X circulate through stall. It also zeroes `stall_cycles`.
- Output values during reset: stall=0, all fwd_sel=0, stall_cycles=0. This holds while reset is high, regardless of the D inputs.
- Reset asserted mid-stall: stall drops in the same cycle, and in-flight producers are lost.
- Simultaneous data stall and md stall: stall=1, counted once.
- During a stall, M/W keep advancing and tnew keeps decrementing, so a stall always resolves.

## Structure
- Package `hazard_pkg`: TUSE_NONE (all ones), FWD_RF=0, and the entry struct {valid, dst, tnew, src}.
- Sub-module `hazard_port_check`: for one source address, Tuse and the entry vector, it returns a stall bit and a select. It is instantiated NSTAGE*NRD times for forwarding and NRD times for stall.
- The top level holds the entry shift register and the counter.

## Test plan
- Reset with d_valid=1 and random inputs: stall=0, all fwd_sel=0 and stall_cycles=0 during reset and on the first cycle after it.
- lw $5 (tnew 2), then addu $6,$5,$0 (tuse 1): one stall cycle. Then D select 0, E-consumer port0 select=1 (W) one edge later, and stall_cycles=1.
- addu $3 (tnew 1), then beq $3 (tuse 0): one stall. Next cycle the D select for $3 is 2 (M).
- jal (tnew 0, dst 31), then jr $31: no stall, and the D select is 3 (E).
- Two writers of $4 in E (tnew 0) and M (tnew 0): the D select is 3, so the youngest writer wins. Writes to $0: select 0 and no stall.
- md_busy=1 with mfhi in D for 5 cycles: stall is held for 5 cycles and stall_cycles=5. An instruction without md_use under md_busy does not stall.
